cpa_pipeline_stage: RTL and testbench

//  Final carry-propagate adder of the multiplier datapath; sits directly downstream of the last

---
 rtl/mult_pkg.sv | 14 +
 rtl/cpa_pipeline_stage_if.sv | 26 ++
 rtl/cpa_pipeline_stage_slice.sv | 23 ++
 rtl/cpa_pipeline_stage.sv | 110 +++++++++++
 tb/tb_cpa_pipeline_stage.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared multiplier datapath constants, used by the reduction stages and the
// final carry-propagate adder.
package mult_pkg;

  localparam int MULT_WIDTH = 16;

  // Stage 1 adds the low half and stage 2 adds the remaining high bits.
  function automatic int split_point(input int width);
    return width / 2;
  endfunction

  localparam int MULT_SPLIT = split_point(MULT_WIDTH);

endpackage

// File: rtl/cpa_pipeline_stage_if.sv
// Valid/ready bus between the last carry-save stage, the carry-propagate adder
// and the product consumer.
interface cpa_pipeline_stage_if #(
  parameter int WIDTH = mult_pkg::MULT_WIDTH
);

  logic [WIDTH-1:0] s_vec;
  logic [WIDTH-1:0] c_vec;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] product;
  logic             cout;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output s_vec, c_vec, in_valid, out_ready,
    input  in_ready, product, cout, out_valid
  );

  modport slave (
    input  s_vec, c_vec, in_valid, out_ready,
    output in_ready, product, cout, out_valid
  );

endinterface

// File: rtl/cpa_pipeline_stage_slice.sv
// N-bit ripple-carry chain of full-adder cells; one instance per pipeline stage.
module cpa_slice #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/cpa_pipeline_stage.sv
// Two-stage final carry-propagate adder: low half in stage 1, high half plus the
// registered low-half carry in stage 2, with valid/ready flow control and a global enable.
module cpa_pipeline_stage
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int SPLIT = split_point(WIDTH)
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 en,
  cpa_pipeline_stage_if.slave bus
);

  localparam int HI_W = WIDTH - SPLIT;

  logic             v1;
  logic             v2;
  logic [SPLIT-1:0] lo_reg;
  logic             c1_reg;
  logic [HI_W-1:0]  s_hi_reg;
  logic [HI_W-1:0]  c_hi_reg;
  logic [WIDTH-1:0] product_reg;
  logic             cout_reg;

  logic [SPLIT-1:0] lo_sum;
  logic             lo_cout;
  logic [HI_W-1:0]  hi_sum;
  logic             hi_cout;

  logic ready1;
  logic ready2;
  logic accept;
  logic advance;
  logic retire;

  // A stage can take new data when it is empty or its contents move on this cycle.
  assign ready2  = !v2 || bus.out_ready;
  assign ready1  = !v1 || ready2;
  assign accept  = bus.in_valid && en && ready1;
  assign advance = en && v1 && ready2;
  assign retire  = en && v2 && bus.out_ready;

  assign bus.in_ready  = en && ready1;
  assign bus.out_valid = v2;
  assign bus.product   = product_reg;
  assign bus.cout      = cout_reg;

  cpa_slice #(.N(SPLIT)) u_lo (
    .a    (bus.s_vec[SPLIT-1:0]),
    .b    (bus.c_vec[SPLIT-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  cpa_slice #(.N(HI_W)) u_hi (
    .a    (s_hi_reg),
    .b    (c_hi_reg),
    .cin  (c1_reg),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  // Accept wins over advance for v1, advance wins over retire for v2, so a
  // simultaneous accept/advance/retire keeps both stages occupied in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (accept) begin
        v1 <= 1'b1;
      end else if (advance) begin
        v1 <= 1'b0;
      end
      if (advance) begin
        v2 <= 1'b1;
      end else if (retire) begin
        v2 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_reg   <= '0;
      c1_reg   <= 1'b0;
      s_hi_reg <= '0;
      c_hi_reg <= '0;
    end else if (accept) begin
      lo_reg   <= lo_sum;
      c1_reg   <= lo_cout;
      s_hi_reg <= bus.s_vec[WIDTH-1:SPLIT];
      c_hi_reg <= bus.c_vec[WIDTH-1:SPLIT];
    end
  end

  // Output registers only load on advance, so a stalled result stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product_reg <= '0;
      cout_reg    <= 1'b0;
    end else if (advance) begin
      product_reg <= {hi_sum, lo_reg};
      cout_reg    <= hi_cout;
    end
  end

endmodule

// File: tb/tb_cpa_pipeline_stage.sv
// Directed self-checking bench for cpa_pipeline_stage (WIDTH=16) with a small
// in-order scoreboard of hand-computed {cout, product} results.
module tb_cpa_pipeline_stage;

  logic clk;
  logic rst;
  logic en;

  int checks   = 0;
  int failures = 0;

  logic [16:0] expq[$];
  logic [15:0] held;

  cpa_pipeline_stage_if #(.WIDTH(16)) bus ();

  cpa_pipeline_stage #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] s, input logic [15:0] c,
                                input logic valid, input logic [16:0] result);
    bus.s_vec    = s;
    bus.c_vec    = c;
    bus.in_valid = valid;
    if (valid) expq.push_back(result);
  endtask

  // Called at a falling edge: scores the transfers of the coming rising edge.
  task automatic tick(input string tag);
    logic [16:0] exp_val;
    #1;
    if (bus.out_valid && bus.out_ready && en) begin
      if (expq.size() == 0) begin
        check_output({tag, "_spurious"}, 32'(bus.out_valid), 32'd0);
      end else begin
        exp_val = expq.pop_front();
        check_output({tag, "_result"}, {15'd0, bus.cout, bus.product}, {15'd0, exp_val});
      end
    end
    @(posedge clk);
    @(negedge clk);
    // Entries queued but not accepted this edge are withdrawn by the caller.
  endtask

  // Offer one vector and require it to be accepted on the next edge.
  task automatic send(input string tag, input logic [15:0] s, input logic [15:0] c,
                      input logic [16:0] result);
    apply_stimulus(s, c, 1'b1, result);
    #1;
    check_output({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick(tag);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.in_valid = 1'b0;
    while (expq.size() > 0 && n < 20) begin
      tick(tag);
      n++;
    end
    check_output({tag, "_pending"}, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    en            = 1'b1;
    bus.s_vec     = '0;
    bus.c_vec     = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_product", 32'(bus.product), 32'd0);
    check_output("rst_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: low-half carry crosses into stage 2; two-edge latency.
    send("t1", 16'h00FF, 16'h0001, 17'h0_0100);
    bus.in_valid = 1'b0;
    check_output("t1_lat1", 32'(bus.out_valid), 32'd0);
    tick("t1");
    check_output("t1_lat2", 32'(bus.out_valid), 32'd1);
    check_output("t1_product", 32'(bus.product), 32'h0100);
    drain("t1");

    // Test 2: wrap with carry out, then a plain sum.
    send("t2", 16'hFFFF, 16'h0001, 17'h1_0000);
    send("t2", 16'h1234, 16'h4321, 17'h0_5555);
    drain("t2");

    // Test 3: four back-to-back vectors, one result per cycle.
    send("t3", 16'h0001, 16'h0002, 17'h0_0003);
    send("t3", 16'hA5A5, 16'h5A5A, 17'h0_FFFF);
    send("t3", 16'hF000, 16'h1000, 17'h1_0000);
    send("t3", 16'h7FFF, 16'h0001, 17'h0_8000);
    bus.in_valid = 1'b0;
    check_output("t3_cons3", 32'(bus.out_valid), 32'd1);
    tick("t3");
    check_output("t3_cons4", 32'(bus.out_valid), 32'd1);
    tick("t3");
    check_output("t3_empty", 32'(bus.out_valid), 32'd0);
    drain("t3");

    // Test 4: consumer stalled, capacity of two, then drain in order.
    bus.out_ready = 1'b0;
    send("t4", 16'h8000, 16'h8000, 17'h1_0000);
    send("t4", 16'h0F0F, 16'h00F1, 17'h0_1000);
    apply_stimulus(16'h7FFF, 16'h7FFF, 1'b1, 17'h0_FFFE);
    #1;
    check_output("t4_full", 32'(bus.in_ready), 32'd0);
    held = bus.product;
    check_output("t4_head", 32'({bus.cout, bus.product}), 32'h1_0000);
    tick("t4");
    check_output("t4_stable1", 32'(bus.product), 32'(held));
    tick("t4");
    check_output("t4_stable2", 32'(bus.product), 32'(held));
    check_output("t4_valid_held", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    #1;
    check_output("t4_reopen", 32'(bus.in_ready), 32'd1);
    tick("t4");
    drain("t4");

    // Test 5: global enable freezes two results in flight.
    send("t5", 16'h1111, 16'h2222, 17'h0_3333);
    send("t5", 16'hFF00, 16'h0100, 17'h1_0000);
    en = 1'b0;
    bus.s_vec    = 16'h0004;
    bus.c_vec    = 16'h0004;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output("t5_in_ready", 32'(bus.in_ready), 32'd0);
      check_output("t5_frozen", 32'({bus.out_valid, bus.cout, bus.product}), 32'h2_3333);
      tick("t5");
    end
    en = 1'b1;
    drain("t5");

    // Test 6: asynchronous reset with two in flight, then a fresh transfer.
    bus.out_ready = 1'b0;
    send("t6", 16'h0102, 16'h0304, 17'h0_0406);
    send("t6", 16'h1000, 16'h2000, 17'h0_3000);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_output("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check_output("t6_rst_product", 32'(bus.product), 32'd0);
    expq.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send("t6", 16'h0003, 16'h0005, 17'h0_0008);
    bus.in_valid = 1'b0;
    check_output("t6_lat1", 32'(bus.out_valid), 32'd0);
    tick("t6");
    check_output("t6_lat2", 32'({bus.out_valid, bus.product}), 32'h1_0008);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
